ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  discard the held entry and any capture this cycle.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the decode-side handshake.
REQ-006 SHALL have ports in_opcode input 5 (ALU op code) and in_s_32 input 1 (32-bit word op).
REQ-007 SHALL have ports in_rs1_val and in_rs2_val, input XLEN each, carrying register-file read data.
REQ-008 SHALL have ports in_rs1_addr and in_rs2_addr, input 5 each, carrying source register indices.
REQ-009 SHALL have ports in_imm input XLEN, in_use_imm input 1, in_pc input XLEN, in_use_pc input 1, in_rd_addr input 5.
REQ-010 SHALL have ports mem_fwd_en input 1, mem_fwd_rd input 5, mem_fwd_data input XLEN (MEM-stage result).
REQ-011 SHALL have ports wb_fwd_en input 1, wb_fwd_rd input 5, wb_fwd_data input XLEN (WB-stage result).
REQ-012 SHALL have ports out_valid output 1 and out_ready input 1, the ALU-side handshake.
REQ-013 SHALL have ports alu_opcode output 5, alu_s_32 output 1, alu_rs1 output XLEN, alu_rs2 output XLEN, out_rd_addr output 5, all registered and feeding the ALU directly.

Function
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL capture on in_valid && in_ready && !flush, setting out_valid = 1 on the next cycle, with 1-cycle latency.
REQ-016 SHALL clear out_valid when out_ready && out_valid and no capture occurs in the same cycle; a simultaneous drain and capture keeps out_valid = 1 with the new entry.
REQ-017 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-018 SHALL select operand 1 as follows: in_pc if in_use_pc, else the forwarded rs1 value.
REQ-019 SHALL select operand 2 as follows: in_imm if in_use_imm, else the forwarded rs2 value.
REQ-020 SHALL resolve the forwarded value in priority order: mem match (mem_fwd_en && mem_fwd_rd == addr), then wb match, then register-file value.
REQ-021 SHALL never forward for address 0; x0 yields the register-file value unchanged.
REQ-022 SHALL store the source addresses and register-sourced flags of the held entry.
REQ-023 SHALL, each stalled cycle, overwrite a register-sourced held operand on an mem or wb match using the same priority, so that operands are never stale on release.
REQ-024 SHALL, when flush is asserted, set out_valid = 0 on the next cycle regardless of in_valid or out_ready; data registers may retain their values.
REQ-025 SHALL pass in_opcode, in_s_32 and in_rd_addr through unmodified, with no opcode decoding.

Reset
REQ-026 SHALL set, on rst high at a clock edge: out_valid = 0, alu_opcode = 0, alu_s_32 = 0, alu_rs1 = 0, alu_rs2 = 0, out_rd_addr = 0, and the stored addresses and flags = 0.
REQ-027 SHALL give rst priority over flush and capture; in_ready = 1 in the cycle after reset.

Configuration
REQ-028 SHALL, with macro EX_OPERAND_FWD_EN defined, implement REQ-020 through REQ-023.
REQ-029 SHALL, with EX_OPERAND_FWD_EN undefined, take register operands from in_rs*_val only, leave all mem_* and wb_* ports unused, perform no held-entry refresh, and keep the port list unchanged.

Verification
REQ-030 SHALL verify that in_valid=1, in_rs1_val=5, in_rs2_val=7, in_opcode=ADD, out_ready=1 produces, one cycle later, out_valid=1, alu_rs1=5, alu_rs2=7.
REQ-031 SHALL verify that in_rs1_addr=3, mem_fwd_rd=3 with data 0xAA, and wb_fwd_rd=3 with data 0xBB, both enabled, produce alu_rs1=0xAA; repeat with in_rs1_addr=0 and expect in_rs1_val.
REQ-032 SHALL verify that with out_ready=0 holding an entry with rs2_addr=4, a wb_fwd_rd=4 pulse with data 0x1234 produces alu_rs2=0x1234 the next cycle and in_ready=0 throughout.
REQ-033 SHALL verify that in_use_imm=1, in_imm=0xFFFFFFF0 and a mem match on rs2 produce alu_rs2=0xFFFFFFF0 (immediate wins).
REQ-034 SHALL verify that flush and in_valid asserted together with out_valid=1 produce out_valid=0 the next cycle, after which the next in_valid is accepted.
REQ-035 SHALL verify that asserting rst during a stalled entry produces out_valid=0 and all outputs 0 the next cycle; with EX_OPERAND_FWD_EN undefined, repeating REQ-031 yields in_rs1_val.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   Pipeline register between decode and the ALU. Captures one decoded
//   instruction, resolves its two ALU operands (PC / immediate / forwarded
//   register value), and presents them to the ALU over a valid/ready
//   handshake. This register is the only storage between decode and the ALU.
//
//   Optional feature macro: EX_OPERAND_FWD_EN
//     defined   : register operands are forwarded from the MEM stage (highest
//                 priority) and then the WB stage. A held entry that is
//                 stalled keeps picking up matching results, so it is never
//                 stale when it is released.
//     undefined : register operands come from in_rs*_val only. The mem_* and
//                 wb_* ports stay in the port list but are ignored.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     flush               drop the held entry and any capture this cycle
//     in_valid/in_ready   decode-side handshake
//     in_*                decoded instruction fields and register-file data
//     mem_fwd_*, wb_fwd_* MEM / WB stage results available for forwarding
//     out_valid/out_ready ALU-side handshake
//     alu_*, out_rd_addr  registered operands and pass-through fields
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_opcode,
  input  logic            in_s_32,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_use_pc,
  input  logic [4:0]      in_rd_addr,
  input  logic            mem_fwd_en,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_en,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      alu_opcode,
  output logic            alu_s_32,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [4:0]      out_rd_addr
);

  logic            valid_q, valid_d;
  logic [4:0]      opcode_q, opcode_d;
  logic            s32_q, s32_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d;
  logic [4:0]      rs2_addr_q, rs2_addr_d;
  // Operand came from the register file (not PC / immediate) and may
  // therefore be refreshed by forwarding while stalled.
  logic            rs1_reg_q, rs1_reg_d;
  logic            rs2_reg_q, rs2_reg_d;

  logic            capture;
  logic            stall;

  logic [XLEN-1:0] in_rs1_fwd;
  logic [XLEN-1:0] in_rs2_fwd;
  logic [XLEN-1:0] held_rs1_fwd;
  logic [XLEN-1:0] held_rs2_fwd;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  // Capture cannot coincide with a stall: in_ready is low whenever stalled.
  assign stall    = valid_q && !out_ready && !flush;

`ifdef EX_OPERAND_FWD_EN
  // MEM result is younger than WB, so it wins. x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_val,
    input logic            m_en,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_data,
    input logic            w_en,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] r;
    r = rf_val;
    if (addr != 5'd0) begin
      if (m_en && (m_rd == addr)) begin
        r = m_data;
      end else if (w_en && (w_rd == addr)) begin
        r = w_data;
      end
    end
    return r;
  endfunction

  assign in_rs1_fwd   = fwd_sel(in_rs1_addr, in_rs1_val, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                                wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign in_rs2_fwd   = fwd_sel(in_rs2_addr, in_rs2_val, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                                wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign held_rs1_fwd = fwd_sel(rs1_addr_q, rs1_q, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                                wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign held_rs2_fwd = fwd_sel(rs2_addr_q, rs2_q, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                                wb_fwd_en, wb_fwd_rd, wb_fwd_data);
`else
  assign in_rs1_fwd   = in_rs1_val;
  assign in_rs2_fwd   = in_rs2_val;
  assign held_rs1_fwd = rs1_q;
  assign held_rs2_fwd = rs2_q;

  // Forwarding inputs and stored source addresses have no consumer here.
  logic unused_fwd;
  assign unused_fwd = ^{mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                        wb_fwd_en, wb_fwd_rd, wb_fwd_data,
                        rs1_addr_q, rs2_addr_q};
`endif

  always_comb begin
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    s32_d      = s32_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_reg_d  = rs1_reg_q;
    rs2_reg_d  = rs2_reg_q;

    if (capture) begin
      opcode_d   = in_opcode;
      s32_d      = in_s_32;
      rd_d       = in_rd_addr;
      rs1_addr_d = in_rs1_addr;
      rs2_addr_d = in_rs2_addr;
      rs1_reg_d  = !in_use_pc;
      rs2_reg_d  = !in_use_imm;
      rs1_d      = in_use_pc  ? in_pc  : in_rs1_fwd;
      rs2_d      = in_use_imm ? in_imm : in_rs2_fwd;
    end else if (stall) begin
      if (rs1_reg_q) rs1_d = held_rs1_fwd;
      if (rs2_reg_q) rs2_d = held_rs2_fwd;
    end

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      s32_q      <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_reg_q  <= 1'b0;
      rs2_reg_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      s32_q      <= s32_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_reg_q  <= rs1_reg_d;
      rs2_reg_q  <= rs2_reg_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_opcode  = opcode_q;
  assign alu_s_32    = s32_q;
  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign out_rd_addr = rd_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  localparam logic [4:0] OP_ADD = 5'd0;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready;
  logic [4:0]      in_opcode;
  logic            in_s_32;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic            in_use_imm, in_use_pc;
  logic            mem_fwd_en, wb_fwd_en;
  logic [4:0]      mem_fwd_rd, wb_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data, wb_fwd_data;
  logic            out_valid, out_ready;
  logic [4:0]      alu_opcode, out_rd_addr;
  logic            alu_s_32;
  logic [XLEN-1:0] alu_rs1, alu_rs2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one held entry with its source info.
  logic            m_valid;
  logic [4:0]      m_op, m_rd, m_a1, m_a2;
  logic            m_s32, m_r1, m_r2;
  logic [XLEN-1:0] m_rs1, m_rs2;

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_s_32(in_s_32),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_pc(in_pc), .in_use_pc(in_use_pc), .in_rd_addr(in_rd_addr),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_opcode(alu_opcode), .alu_s_32(alu_s_32),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .out_rd_addr(out_rd_addr)
  );

  always #5 clk = ~clk;

  // Value a register read of 'a' should see, given the current bypass buses.
  function automatic logic [XLEN-1:0] ref_resolve(input logic [4:0] a, input logic [XLEN-1:0] rf);
`ifdef EX_OPERAND_FWD_EN
    if (a != 5'd0 && mem_fwd_en && mem_fwd_rd == a) return mem_fwd_data;
    if (a != 5'd0 && wb_fwd_en && wb_fwd_rd == a) return wb_fwd_data;
`endif
    return rf;
  endfunction

  task automatic idle_inputs();
    rst = 0; flush = 0; in_valid = 0; in_opcode = 0; in_s_32 = 0;
    in_rs1_val = 0; in_rs2_val = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_imm = 0; in_use_imm = 0; in_pc = 0; in_use_pc = 0; in_rd_addr = 0;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0; out_ready = 1;
  endtask

  // Advance one clock, updating the model from the inputs applied this cycle.
  task automatic tick();
    logic cap, nv, ns32, nr1, nr2;
    logic [4:0] nop, nrd, na1, na2;
    logic [XLEN-1:0] nrs1, nrs2;
    nv = m_valid; nop = m_op; ns32 = m_s32; nrd = m_rd; na1 = m_a1; na2 = m_a2;
    nr1 = m_r1; nr2 = m_r2; nrs1 = m_rs1; nrs2 = m_rs2;
    cap = in_valid && (!m_valid || out_ready) && !flush;
    if (rst) begin
      nv = 0; nop = 0; ns32 = 0; nrd = 0; na1 = 0; na2 = 0; nr1 = 0; nr2 = 0; nrs1 = 0; nrs2 = 0;
    end else begin
      if (cap) begin
        nop = in_opcode; ns32 = in_s_32; nrd = in_rd_addr; na1 = in_rs1_addr; na2 = in_rs2_addr;
        nr1 = !in_use_pc; nr2 = !in_use_imm;
        nrs1 = in_use_pc ? in_pc : ref_resolve(in_rs1_addr, in_rs1_val);
        nrs2 = in_use_imm ? in_imm : ref_resolve(in_rs2_addr, in_rs2_val);
      end else if (m_valid && !out_ready && !flush) begin
        if (m_r1) nrs1 = ref_resolve(m_a1, m_rs1);
        if (m_r2) nrs2 = ref_resolve(m_a2, m_rs2);
      end
      if (flush) nv = 0;
      else if (cap) nv = 1;
      else if (out_ready) nv = 0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_op = nop; m_s32 = ns32; m_rd = nrd; m_a1 = na1; m_a2 = na2;
    m_r1 = nr1; m_r2 = nr2; m_rs1 = nrs1; m_rs2 = nrs2;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    rst = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (alu_opcode !== 5'd0) $display("FAIL reset_opcode: got %h expected 0", alu_opcode); else n_pass++;
    n_checks++; if (alu_s_32 !== 1'b0) $display("FAIL reset_s32: got %b expected 0", alu_s_32); else n_pass++;
    n_checks++; if (alu_rs1 !== '0) $display("FAIL reset_rs1: got %h expected 0", alu_rs1); else n_pass++;
    n_checks++; if (alu_rs2 !== '0) $display("FAIL reset_rs2: got %h expected 0", alu_rs2); else n_pass++;
    n_checks++; if (out_rd_addr !== 5'd0) $display("FAIL reset_rd: got %h expected 0", out_rd_addr); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    idle_inputs();
    in_valid = 1; in_opcode = OP_ADD; in_s_32 = 1; in_rd_addr = 5'd9;
    in_rs1_addr = 5'd1; in_rs2_addr = 5'd2; in_rs1_val = 5; in_rs2_val = 7;
    tick();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (alu_rs1 !== 32'd5) $display("FAIL basic_rs1: got %h expected 5", alu_rs1); else n_pass++;
    n_checks++; if (alu_rs2 !== 32'd7) $display("FAIL basic_rs2: got %h expected 7", alu_rs2); else n_pass++;
    n_checks++; if (out_rd_addr !== 5'd9 || alu_s_32 !== 1'b1 || alu_opcode !== OP_ADD)
      $display("FAIL basic_passthru: got rd=%h s32=%b op=%h expected rd=09 s32=1 op=00", out_rd_addr, alu_s_32, alu_opcode);
    else n_pass++;
    in_valid = 0; tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    logic [XLEN-1:0] exp;
    idle_inputs();
    in_valid = 1; in_rs1_addr = 5'd3; in_rs1_val = 32'h11;
    mem_fwd_en = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hAA;
    wb_fwd_en = 1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hBB;
    tick();
`ifdef EX_OPERAND_FWD_EN
    exp = 32'hAA;
`else
    exp = 32'h11;
`endif
    n_checks++; if (alu_rs1 !== exp) $display("FAIL fwd_mem_priority: got %h expected %h", alu_rs1, exp); else n_pass++;
    mem_fwd_en = 0;
    tick();
`ifdef EX_OPERAND_FWD_EN
    exp = 32'hBB;
`else
    exp = 32'h11;
`endif
    n_checks++; if (alu_rs1 !== exp) $display("FAIL fwd_wb: got %h expected %h", alu_rs1, exp); else n_pass++;
    mem_fwd_en = 1; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0; in_rs1_addr = 5'd0;
    tick();
    n_checks++; if (alu_rs1 !== 32'h11) $display("FAIL fwd_x0: got %h expected 11", alu_rs1); else n_pass++;
    idle_inputs(); tick();
  endtask

  task automatic test_stall_refresh();
    logic [XLEN-1:0] exp;
    idle_inputs();
    out_ready = 0; in_valid = 1; in_rs2_addr = 5'd4; in_rs2_val = 32'h55;
    tick();
    in_valid = 0; #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready0: got %b expected 0", in_ready); else n_pass++;
    wb_fwd_en = 1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h1234;
    tick();
    wb_fwd_en = 0; #1;
`ifdef EX_OPERAND_FWD_EN
    exp = 32'h1234;
`else
    exp = 32'h55;
`endif
    n_checks++; if (alu_rs2 !== exp) $display("FAIL stall_refresh: got %h expected %h", alu_rs2, exp); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready1: got %b expected 0", in_ready); else n_pass++;
    tick();
    n_checks++; if (alu_rs2 !== exp || out_valid !== 1'b1) $display("FAIL stall_hold: got %h/%b expected %h/1", alu_rs2, out_valid, exp); else n_pass++;
    out_ready = 1; tick();
  endtask

  task automatic test_imm_wins();
    idle_inputs();
    in_valid = 1; in_use_imm = 1; in_imm = 32'hFFFF_FFF0; in_rs2_addr = 5'd5; in_rs2_val = 32'h77;
    mem_fwd_en = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hDEAD;
    tick();
    n_checks++; if (alu_rs2 !== 32'hFFFF_FFF0) $display("FAIL imm_wins: got %h expected fffffff0", alu_rs2); else n_pass++;
    idle_inputs(); in_valid = 1; in_use_pc = 1; in_pc = 32'h8000_0040; in_rs1_addr = 5'd5;
    mem_fwd_en = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hDEAD;
    tick();
    n_checks++; if (alu_rs1 !== 32'h8000_0040) $display("FAIL pc_wins: got %h expected 80000040", alu_rs1); else n_pass++;
    idle_inputs(); tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    out_ready = 0; in_valid = 1; in_rs1_val = 32'h1; tick();
    flush = 1; in_rs1_val = 32'h2; tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid); else n_pass++;
    flush = 0; in_rs1_val = 32'h3; #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || alu_rs1 !== 32'h3) $display("FAIL flush_accept: got %b/%h expected 1/3", out_valid, alu_rs1); else n_pass++;
    idle_inputs(); tick();
  endtask

  task automatic test_reset_stalled();
    idle_inputs();
    out_ready = 0; in_valid = 1; in_opcode = 5'h1F; in_s_32 = 1; in_rd_addr = 5'd7;
    in_rs1_val = 32'hCAFE; in_rs2_val = 32'hBEEF; tick();
    rst = 1; tick();
    rst = 0; in_valid = 0; #1;
    n_checks++; if ({out_valid, alu_opcode, alu_s_32, alu_rs1, alu_rs2, out_rd_addr} !== '0)
      $display("FAIL rst_stalled: got v=%b op=%h s=%b rs1=%h rs2=%h rd=%h expected all 0",
               out_valid, alu_opcode, alu_s_32, alu_rs1, alu_rs2, out_rd_addr);
    else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_stalled_in_ready: got %b expected 1", in_ready); else n_pass++;
    idle_inputs(); tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_opcode = 5'($urandom); in_s_32 = 1'($urandom); in_rd_addr = 5'($urandom);
      in_rs1_val = $urandom; in_rs2_val = $urandom; in_imm = $urandom; in_pc = $urandom;
      in_use_imm = ($urandom_range(0, 3) == 0); in_use_pc = ($urandom_range(0, 3) == 0);
      in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
      mem_fwd_en = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
      wb_fwd_en = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 3)); wb_fwd_data = $urandom;
      #1;
      if (errs < 10) begin
        n_checks++;
        if (in_ready !== (!m_valid || out_ready)) begin
          $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, (!m_valid || out_ready)); errs++;
        end else n_pass++;
      end
      tick();
      if (errs < 10) begin
        n_checks++;
        if (out_valid !== m_valid) begin
          $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, m_valid); errs++;
        end else n_pass++;
        if (m_valid) begin
          n_checks++;
          if ({alu_opcode, alu_s_32, alu_rs1, alu_rs2, out_rd_addr} !== {m_op, m_s32, m_rs1, m_rs2, m_rd}) begin
            $display("FAIL rand_data[%0d]: got op=%h s=%b rs1=%h rs2=%h rd=%h expected op=%h s=%b rs1=%h rs2=%h rd=%h",
                     i, alu_opcode, alu_s_32, alu_rs1, alu_rs2, out_rd_addr, m_op, m_s32, m_rs1, m_rs2, m_rd);
            errs++;
          end else n_pass++;
        end
      end
    end
    idle_inputs(); tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_fwd_priority();
    test_stall_refresh();
    test_imm_wins();
    test_flush();
    test_reset_stalled();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
